yarp_data_mem_ctrl: RTL and testbench
=====================================

# yarp_data_mem_ctrl

Load/store unit sitting downstream of `yarp_execute`. It takes the ALU result as the effective address, runs a request/grant/response transaction on the single-port data-memory bus, and returns formatted load data to writeback. It handles byte-lane steering, byte enables, sign/zero extension and misalignment detection. It is a blocking unit with one transaction in flight.

## Interface
- `XLEN`: 32, from `yarp_pkg`. This is not a local parameter, and the block supports 32 only.
- `clk` in 1: the single clock, rising edge.
- `reset` in 1: asynchronous assert, active-high. Drives the FSM to IDLE and every output to 0.
- `req_valid_i` in 1: execute presents a memory op.
- `req_ready_o` out 1: the unit can accept a request. High only in IDLE.
- `req_addr_i` in XLEN: effective address (ALU result).
- `req_wdata_i` in XLEN: store data (rs2). Only bits [7:0] or [15:0] are used for byte/half stores.
- `req_we_i` in 1: 1 for a store, 0 for a load.
- `req_size_i` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_zero_extnd_i` in 1: on loads, 1 selects zero-extension (LBU/LHU) and 0 selects sign-extension.
- `rsp_valid_o` out 1: one-cycle pulse when a transaction completes.
- `rsp_rdata_o` out XLEN: formatted load data. It is 0 for stores and errors, and holds its value until the next response.
- `rsp_err_o` out 1: valid with `rsp_valid_o`. Flags a misaligned access or illegal size.
- `mem_req_o` out 1: bus request.
- `mem_we_o` out 1: bus write.
- `mem_addr_o` out XLEN: word-aligned address, `{req_addr[31:2],2'b00}`.
- `mem_byte_en_o` out 4: byte-lane enables, valid for both reads and writes.
- `mem_wdata_o` out XLEN: lane-steered store data.
- `mem_gnt_i` in 1: the memory accepted the request this cycle.
- `mem_rvalid_i` in 1: response valid (read data or write ack).
- `mem_rdata_i` in XLEN: the full read word.

## Operation
- The FSM states are IDLE, REQ, WAIT and RESP. Reset enters IDLE.
- **IDLE**
  - `req_ready_o`=1.
  - On `req_valid_i`, capture addr, wdata, we, size and zero_extnd into registers.
  - If the access is misaligned, go to RESP with the error flag set. Otherwise go to REQ.
- **Misalignment / illegal rules**
  - A half access with addr[0]=1 is misaligned.
  - A word access with addr[1:0]≠0 is misaligned.
  - size=11 is illegal.
  - Errors never assert `mem_req_o`.
- **REQ**
  - `mem_req_o`=1, with `mem_we_o`, `mem_addr_o`, `mem_byte_en_o` and `mem_wdata_o` all stable.
  - Go to WAIT on `mem_gnt_i`. Otherwise stay; the request is held with no timeout.
- **WAIT**
  - `mem_req_o`=0.
  - On `mem_rvalid_i`, register the formatted data (loads) or 0 (stores), then go to RESP.
  - `mem_rvalid_i` is ignored in every state except WAIT.
- **RESP**
  - `rsp_valid_o`=1 for exactly one cycle, with `rsp_err_o` as captured. Then go to IDLE.
  - There is no backpressure on the response.
- **Byte enables**, with off = addr[1:0]:
  - byte: `4'b0001<<off`
  - half: `4'b0011<<off`
  - word: `4'b1111`
- **Write data**:
  - byte: `{4{wdata[7:0]}}`
  - half: `{2{wdata[15:0]}}`
  - word: wdata
- **Load formatting**:
  - byte = `rdata[8*off+:8]`.
  - half = `rdata[16*off[1]+:16]`.
  - The result is extended to XLEN: zero-extended when zero_extnd=1, sign-extended from the top bit otherwise.
  - word = rdata unchanged; zero_extnd is ignored.
- **Reset mid-transaction**:
  - Immediate return to IDLE, with `mem_req_o` and `rsp_valid_o` at 0.
  - A late `mem_rvalid_i` for the aborted access arrives while the FSM is not in WAIT, so it is ignored.

## Timing
- Accepting a request on edge 0 gives:
  - `mem_req_o` high in the cycle after edge 0.
  - With a same-cycle grant and `mem_rvalid_i` one cycle later, `rsp_valid_o` is high 3 cycles after acceptance. This is the minimum latency.
- Each grant-stall cycle and each rvalid-wait cycle adds 1 cycle.
- A misaligned or illegal request gives `rsp_valid_o` 1 cycle after acceptance.
- Back-to-back issue: the next request can be accepted in the IDLE cycle following RESP, so throughput is at most one op per 4 cycles.
- All `mem_*` and `rsp_*` outputs are registered or decoded from registered state only. There is no combinational path from `req_*` or `mem_*` inputs to any output.
- Reset values: `req_ready_o`=0 while reset is asserted, then 1 in IDLE. Every other output is 0.

## Test plan
- **LW, aligned, no stall.** addr 0x100, gnt in first REQ cycle, rvalid next cycle, rdata 0xDEADBEEF.
  - Expect `mem_addr_o`=0x100, byte_en=1111.
  - Expect `rsp_valid_o` 3 cycles after accept, rdata 0xDEADBEEF, err=0.
- **LB sign-extend and LBU zero-extend.** addr 0x103, rdata 0x80123456.
  - LB: expect byte_en=1000, rsp_rdata 0xFFFFFF80.
  - LBU on the same data: expect 0x00000080.
- **LHU, upper half.** addr 0x202, rdata 0xBEEF1234, zero_extnd=1.
  - Expect byte_en=1100, rsp_rdata 0x0000BEEF.
- **SB, offset 1.** addr 0x301, wdata 0x000000A5.
  - Expect `mem_we_o`=1, byte_en=0010, `mem_wdata_o`=0xA5A5A5A5.
  - Expect rsp_rdata 0, err=0.
- **Misaligned LW and illegal size.**
  - LW at addr 0x102: expect `rsp_valid_o`+`rsp_err_o` 1 cycle after accept, with `mem_req_o` never asserted.
  - Repeat with size=11: same response expected.
- **Grant stall, then reset abort.**
  - Hold gnt low 3 cycles: expect `mem_req_o` and the bus fields stable throughout, and latency of 6.
  - Assert `reset` in WAIT, then drive rvalid after release: expect no `rsp_valid_o` and `req_ready_o`=1.

Source files
------------

// File: rtl/yarp_data_mem_ctrl.sv
// Load/store unit: one blocking request/grant/response transaction on the data-memory bus,
// with byte-lane steering, byte enables, load extension and misalignment detection.

package yarp_pkg;
    parameter int XLEN = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } mem_size_e;
endpackage

module yarp_data_mem_ctrl
    import yarp_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    input  logic            req_we_i,
    input  logic [1:0]      req_size_i,
    input  logic            req_zero_extnd_i,
    output logic            rsp_valid_o,
    output logic [XLEN-1:0] rsp_rdata_o,
    output logic            rsp_err_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [3:0]      mem_byte_en_o,
    output logic [XLEN-1:0] mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_RESP} state_e;

    state_e          state, state_next;
    logic            accept;
    logic            misaligned;
    logic [3:0]      be_next;
    logic [XLEN-1:0] wdata_next;

    logic [XLEN-1:0] addr_q;
    mem_size_e       size_q;
    logic            zext_q;
    logic            we_q;
    logic [3:0]      be_q;
    logic [XLEN-1:0] wdata_q;
    logic            err_q;
    logic [XLEN-1:0] rdata_q;

    logic [1:0]      off;
    logic [7:0]      lane_byte;
    logic [15:0]     lane_half;
    logic [XLEN-1:0] load_data;

    assign accept = req_valid_i && req_ready_o;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = misaligned ? ST_RESP : ST_REQ;
            ST_REQ:  if (mem_gnt_i) state_next = ST_WAIT;
            ST_WAIT: if (mem_rvalid_i) state_next = ST_RESP;
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = 1'b0;
        mem_req_o   = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_err_o   = 1'b0;
        case (state)
            ST_IDLE: req_ready_o = ~reset;
            ST_REQ:  mem_req_o   = 1'b1;
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                rsp_err_o   = err_q;
            end
            default: ;
        endcase
    end

    // Request-side decode: alignment check, lane enables and replicated store data.
    always_comb begin
        misaligned = 1'b0;
        be_next    = 4'b0000;
        wdata_next = req_wdata_i;
        case (mem_size_e'(req_size_i))
            SIZE_BYTE: begin
                be_next    = 4'b0001 << req_addr_i[1:0];
                wdata_next = {4{req_wdata_i[7:0]}};
            end
            SIZE_HALF: begin
                misaligned = req_addr_i[0];
                be_next    = 4'b0011 << req_addr_i[1:0];
                wdata_next = {2{req_wdata_i[15:0]}};
            end
            SIZE_WORD: begin
                misaligned = |req_addr_i[1:0];
                be_next    = 4'b1111;
            end
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        off       = addr_q[1:0];
        lane_byte = mem_rdata_i[{off, 3'b000} +: 8];
        lane_half = mem_rdata_i[{off[1], 4'b0000} +: 16];
        case (size_q)
            SIZE_BYTE: load_data = zext_q ? {{(XLEN-8){1'b0}}, lane_byte}
                                          : {{(XLEN-8){lane_byte[7]}}, lane_byte};
            SIZE_HALF: load_data = zext_q ? {{(XLEN-16){1'b0}}, lane_half}
                                          : {{(XLEN-16){lane_half[15]}}, lane_half};
            default:   load_data = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q  <= '0;
            size_q  <= SIZE_BYTE;
            zext_q  <= 1'b0;
            we_q    <= 1'b0;
            be_q    <= 4'b0000;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr_i;
                size_q  <= mem_size_e'(req_size_i);
                zext_q  <= req_zero_extnd_i;
                we_q    <= req_we_i;
                be_q    <= be_next;
                wdata_q <= wdata_next;
                err_q   <= misaligned;
                // Errors respond on the very next cycle, so their zero data lands now.
                if (misaligned) rdata_q <= '0;
            end
            if (state == ST_WAIT && mem_rvalid_i)
                rdata_q <= we_q ? '0 : load_data;
        end
    end

    assign rsp_rdata_o   = rdata_q;
    assign mem_we_o      = we_q;
    assign mem_addr_o    = {addr_q[XLEN-1:2], 2'b00};
    assign mem_byte_en_o = be_q;
    assign mem_wdata_o   = wdata_q;

endmodule

// File: tb/tb_yarp_data_mem_ctrl.sv
// Directed bench for yarp_data_mem_ctrl: the bench plays the memory, expected responses are
// queued at issue time and popped when the unit responds.

module tb_yarp_data_mem_ctrl;
    import yarp_pkg::*;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req_valid_i = 1'b0;
    logic            req_ready_o;
    logic [XLEN-1:0] req_addr_i = '0;
    logic [XLEN-1:0] req_wdata_i = '0;
    logic            req_we_i = 1'b0;
    logic [1:0]      req_size_i = 2'b00;
    logic            req_zero_extnd_i = 1'b0;
    logic            rsp_valid_o;
    logic [XLEN-1:0] rsp_rdata_o;
    logic            rsp_err_o;
    logic            mem_req_o;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_addr_o;
    logic [3:0]      mem_byte_en_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic            mem_gnt_i = 1'b0;
    logic            mem_rvalid_i = 1'b0;
    logic [XLEN-1:0] mem_rdata_i = '0;

    yarp_data_mem_ctrl dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid_i      (req_valid_i),
        .req_ready_o      (req_ready_o),
        .req_addr_i       (req_addr_i),
        .req_wdata_i      (req_wdata_i),
        .req_we_i         (req_we_i),
        .req_size_i       (req_size_i),
        .req_zero_extnd_i (req_zero_extnd_i),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_rdata_o      (rsp_rdata_o),
        .rsp_err_o        (rsp_err_o),
        .mem_req_o        (mem_req_o),
        .mem_we_o         (mem_we_o),
        .mem_addr_o       (mem_addr_o),
        .mem_byte_en_o    (mem_byte_en_o),
        .mem_wdata_o      (mem_wdata_o),
        .mem_gnt_i        (mem_gnt_i),
        .mem_rvalid_i     (mem_rvalid_i),
        .mem_rdata_i      (mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          latency;
    } rsp_t;

    rsp_t sb[$];
    int   n_asserts = 0;
    int   n_fails   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, act as the memory (grant after 'stall' REQ cycles, rvalid in the cycle
    // after the grant), then compare the response against the queued expectation.
    task automatic run_op(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic we, input logic [1:0] size, input logic zext,
                          input logic [31:0] mem_word, input int stall,
                          input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                          input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat);
        rsp_t exp_rsp;
        int   lat;
        int   req_cycles;
        bit   granted;
        bit   saw_req;
        bit   done;
        exp_rsp.rdata   = exp_rdata;
        exp_rsp.err     = exp_err;
        exp_rsp.latency = exp_lat;
        sb.push_back(exp_rsp);

        check({name, "/ready"}, 32'(req_ready_o), 32'd1);
        req_valid_i      = 1'b1;
        req_addr_i       = addr;
        req_wdata_i      = wdata;
        req_we_i         = we;
        req_size_i       = size;
        req_zero_extnd_i = zext;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        mem_rdata_i = mem_word;
        lat = 1; req_cycles = 0; granted = 0; saw_req = 0; done = 0;
        while (!done && lat <= 50) begin
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b0;
            if (rsp_valid_o) begin
                done = 1;
            end else begin
                if (mem_req_o) begin
                    saw_req = 1;
                    req_cycles++;
                    check({name, "/mem_addr"}, mem_addr_o, {addr[31:2], 2'b00});
                    check({name, "/byte_en"}, 32'(mem_byte_en_o), 32'(exp_be));
                    check({name, "/mem_we"}, 32'(mem_we_o), 32'(we));
                    if (we) check({name, "/mem_wdata"}, mem_wdata_o, exp_wdata);
                    if (req_cycles > stall) begin
                        mem_gnt_i = 1'b1;
                        granted   = 1;
                    end
                end else if (granted) begin
                    mem_rvalid_i = 1'b1;
                end
                @(negedge clk);
                lat++;
            end
        end
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        check({name, "/no_timeout"}, 32'(done), 32'd1);

        exp_rsp = sb.pop_front();
        check({name, "/rsp_rdata"}, rsp_rdata_o, exp_rsp.rdata);
        check({name, "/rsp_err"}, 32'(rsp_err_o), 32'(exp_rsp.err));
        check({name, "/latency"}, 32'(lat), 32'(exp_rsp.latency));
        check({name, "/bus_used"}, 32'(saw_req), 32'(!exp_err));

        @(negedge clk);
        check({name, "/rsp_one_cycle"}, 32'(rsp_valid_o), 32'd0);
        check({name, "/rdata_hold"}, rsp_rdata_o, exp_rsp.rdata);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst/ready", 32'(req_ready_o), 32'd0);
        check("rst/mem_req", 32'(mem_req_o), 32'd0);
        check("rst/rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst/rsp_err", 32'(rsp_err_o), 32'd0);
        check("rst/byte_en", 32'(mem_byte_en_o), 32'd0);
        check("rst/rsp_rdata", rsp_rdata_o, 32'd0);
        check("rst/mem_addr", mem_addr_o, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        //     name        addr          wdata         we    size   zx    mem word      st  be       exp wdata     err   exp rdata     lat
        run_op("lw",       32'h100, 32'h0,        1'b0, 2'b10, 1'b0, 32'hDEADBEEF, 0, 4'b1111, 32'h0,        1'b0, 32'hDEADBEEF, 3);
        run_op("lb_sx",    32'h103, 32'h0,        1'b0, 2'b00, 1'b0, 32'h80123456, 0, 4'b1000, 32'h0,        1'b0, 32'hFFFFFF80, 3);
        run_op("lbu",      32'h103, 32'h0,        1'b0, 2'b00, 1'b1, 32'h80123456, 0, 4'b1000, 32'h0,        1'b0, 32'h00000080, 3);
        run_op("lb_pos",   32'h101, 32'h0,        1'b0, 2'b00, 1'b0, 32'h00007F00, 0, 4'b0010, 32'h0,        1'b0, 32'h0000007F, 3);
        run_op("lhu_hi",   32'h202, 32'h0,        1'b0, 2'b01, 1'b1, 32'hBEEF1234, 0, 4'b1100, 32'h0,        1'b0, 32'h0000BEEF, 3);
        run_op("lh_lo",    32'h200, 32'h0,        1'b0, 2'b01, 1'b0, 32'h12348001, 0, 4'b0011, 32'h0,        1'b0, 32'hFFFF8001, 3);
        run_op("sb_off1",  32'h301, 32'hA5,       1'b1, 2'b00, 1'b0, 32'h0,        0, 4'b0010, 32'hA5A5A5A5, 1'b0, 32'h0,        3);
        run_op("sh_hi",    32'h402, 32'h1234ABCD, 1'b1, 2'b01, 1'b0, 32'h0,        0, 4'b1100, 32'hABCDABCD, 1'b0, 32'h0,        3);
        run_op("sw",       32'h500, 32'hCAFEF00D, 1'b1, 2'b10, 1'b0, 32'h0,        0, 4'b1111, 32'hCAFEF00D, 1'b0, 32'h0,        3);
        run_op("lw_mis",   32'h102, 32'h0,        1'b0, 2'b10, 1'b0, 32'h0,        0, 4'b0000, 32'h0,        1'b1, 32'h0,        1);
        run_op("size_ill", 32'h100, 32'h0,        1'b0, 2'b11, 1'b0, 32'h0,        0, 4'b0000, 32'h0,        1'b1, 32'h0,        1);
        run_op("lh_mis",   32'h201, 32'h0,        1'b0, 2'b01, 1'b0, 32'h0,        0, 4'b0000, 32'h0,        1'b1, 32'h0,        1);
        run_op("sw_mis",   32'h503, 32'h12345678, 1'b1, 2'b10, 1'b0, 32'h0,        0, 4'b0000, 32'h0,        1'b1, 32'h0,        1);
        run_op("lw_stall", 32'h104, 32'h0,        1'b0, 2'b10, 1'b0, 32'h11223344, 3, 4'b1111, 32'h0,        1'b0, 32'h11223344, 6);

        // Reset abort in WAIT, followed by a late rvalid that must be ignored
        check("abort/ready", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1;
        req_addr_i  = 32'h600;
        req_we_i    = 1'b0;
        req_size_i  = 2'b10;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        check("abort/in_req", 32'(mem_req_o), 32'd1);
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        check("abort/in_wait", 32'(mem_req_o), 32'd0);
        reset = 1'b1;
        #1;
        check("abort/rst_ready", 32'(req_ready_o), 32'd0);
        check("abort/rst_mem_req", 32'(mem_req_o), 32'd0);
        check("abort/rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("abort/rst_rdata", rsp_rdata_o, 32'd0);
        @(negedge clk);
        reset        = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD0BAD0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort/late_rsp_valid", 32'(rsp_valid_o), 32'd0);
            check("abort/late_ready", 32'(req_ready_o), 32'd1);
            check("abort/late_mem_req", 32'(mem_req_o), 32'd0);
        end
        mem_rvalid_i = 1'b0;

        // Recovery after the abort
        run_op("lw_after", 32'h700, 32'h0, 1'b0, 2'b10, 1'b0, 32'h0F0F0F0F, 1, 4'b1111, 32'h0, 1'b0, 32'h0F0F0F0F, 4);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
